// File: rtl/camera_pkg.sv
// camera_pkg
// Shared definitions for the parallel camera interface: the sensor emulator
// FSM state encoding, the test pattern codes, the default frame timing and
// small elaboration-time helpers for sizing counters.
package camera_pkg;

   // Frame sequencing states of the sensor emulator
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFRONT = 3'd4
   } camState_e;

   // Test pattern codes as driven on pattern_sel
   typedef enum logic [1:0] {
      PAT_COUNT = 2'd0,
      PAT_ALT   = 2'd1,
      PAT_GRID  = 2'd2,
      PAT_WHITE = 2'd3
   } pattern_e;

   // Default frame timing, shared with the capture-side bench
   localparam int DEF_PCLK_DIV        = 1;
   localparam int DEF_H_ACTIVE        = 8;
   localparam int DEF_BYTES_PER_PIXEL = 2;
   localparam int DEF_H_BLANK         = 4;
   localparam int DEF_V_SYNC          = 2;
   localparam int DEF_V_BACK          = 2;
   localparam int DEF_V_ACTIVE        = 4;
   localparam int DEF_V_FRONT         = 2;

   // Bits needed for a counter holding 0..numValues-1, never less than one
   function automatic int cntWidth(input int numValues);
      return (numValues <= 2) ? 1 : $clog2(numValues);
   endfunction

   // Largest of four values, used to size the shared line counter
   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
// Combinational test pattern byte for the sensor emulator.
// Ports:
//   i_sel   latched pattern code
//   i_col   byte index within the line
//   i_line  active line index
//   i_href  line valid; the byte is forced to zero when low
//   o_byte  pixel data byte
module camera_pattern_gen
   import camera_pkg::*;
#(
   parameter int COL_W  = 5,
   parameter int LINE_W = 2
)(
   input  pattern_e          i_sel,
   input  logic [COL_W-1:0]  i_col,
   input  logic [LINE_W-1:0] i_line,
   input  logic              i_href,
   output logic [7:0]        o_byte
);

   logic [7:0] w_b;
   logic [3:0] w_y;

   // Counters are resized to the byte and nibble fields the patterns use
   assign w_b = 8'(i_col);
   assign w_y = 4'(i_line);

   // Select the pattern byte; blanking always reads as zero
   always_comb begin
      o_byte = 8'h00;
      if (i_href) begin
         case (i_sel)
            PAT_COUNT: o_byte = w_b;
            PAT_ALT:   o_byte = w_b[0] ? 8'h55 : 8'hAA;
            PAT_GRID:  o_byte = {w_y, w_b[3:0]};
            PAT_WHITE: o_byte = 8'hFF;
            default:   o_byte = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/camera_sensor_emulator.sv
// camera_sensor_emulator
// Emulates the sensor side of a parallel camera interface so the capture
// path can run without a real sensor.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       stream frames continuously while high (sampled at frame boundaries)
//   pattern_sel  test pattern code, latched at frame start
//   Pclk         pixel clock, half period of PCLK_DIV clk cycles
//   Vsync        frame sync, active high
//   Href         line valid, active high
//   Imagen       pixel data byte
//   frame_done   one-clk pulse at the end of each frame
//   busy         high while a frame is in progress
module camera_sensor_emulator
   import camera_pkg::*;
#(
   parameter int PCLK_DIV        = DEF_PCLK_DIV,
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
   parameter int H_BLANK         = DEF_H_BLANK,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FRONT         = DEF_V_FRONT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       Pclk,
   output logic       Vsync,
   output logic       Href,
   output logic [7:0] Imagen,
   output logic       frame_done,
   output logic       busy
);

   localparam int H_BYTES  = H_ACTIVE * BYTES_PER_PIXEL;
   localparam int LINE_LEN = H_BYTES + H_BLANK;
   localparam int V_MAX    = maxOf4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int COL_W    = cntWidth(LINE_LEN);
   localparam int LINE_W   = cntWidth(V_MAX);
   localparam int DIV_W    = cntWidth(PCLK_DIV);

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(PCLK_DIV - 1);
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_LEN - 1);
   localparam logic [COL_W:0]    HREF_LIM   = (COL_W + 1)'(H_BYTES);
   localparam logic [LINE_W-1:0] SYNC_LAST  = LINE_W'(V_SYNC - 1);
   localparam logic [LINE_W-1:0] BACK_LAST  = LINE_W'(V_BACK - 1);
   localparam logic [LINE_W-1:0] ACT_LAST   = LINE_W'(V_ACTIVE - 1);
   localparam logic [LINE_W-1:0] FRONT_LAST = LINE_W'(V_FRONT - 1);

   logic [DIV_W-1:0]  r_divCnt;
   logic              r_pclk;
   camState_e         r_state;
   logic [COL_W-1:0]  r_col;
   logic [LINE_W-1:0] r_line;
   pattern_e          r_sel;
   logic              r_vsync;
   logic              r_href;
   logic [7:0]        r_imagen;
   logic              r_frameDone;
   logic              r_busy;

   logic              w_divLast;
   logic              w_fallTick;
   camState_e         w_nxtState;
   logic [COL_W-1:0]  w_nxtCol;
   logic [LINE_W-1:0] w_nxtLine;
   pattern_e          w_nxtSel;
   logic              w_nxtBusy;
   logic              w_nxtDone;
   logic              w_nxtHref;
   logic [LINE_W-1:0] w_phaseLast;
   logic [7:0]        w_pattern;

   // Divider: Pclk toggles every PCLK_DIV clocks, regardless of enable
   assign w_divLast  = (r_divCnt == DIV_LAST);
   // The frame machinery advances only when Pclk falls, so data is settled
   // a full half period before the receiver samples on the rising edge
   assign w_fallTick = w_divLast & r_pclk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_divCnt <= '0;
         r_pclk   <= 1'b0;
      end else if (w_divLast) begin
         r_divCnt <= '0;
         r_pclk   <= ~r_pclk;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

   // Next-state view of the frame sequencer. Every non-idle phase is a whole
   // number of lines, so one column/line counter pair times all of them and
   // the line counter restarts at each phase change.
   always_comb begin
      w_nxtState  = r_state;
      w_nxtCol    = r_col;
      w_nxtLine   = r_line;
      w_nxtSel    = r_sel;
      w_nxtBusy   = r_busy;
      w_nxtDone   = 1'b0;
      w_phaseLast = FRONT_LAST;
      case (r_state)
         ST_VSYNC:  w_phaseLast = SYNC_LAST;
         ST_VBACK:  w_phaseLast = BACK_LAST;
         ST_ACTIVE: w_phaseLast = ACT_LAST;
         default:   w_phaseLast = FRONT_LAST;
      endcase

      if (r_state == ST_IDLE) begin
         if (enable) begin
            w_nxtState = ST_VSYNC;
            w_nxtSel   = pattern_e'(pattern_sel);
            w_nxtBusy  = 1'b1;
            w_nxtCol   = '0;
            w_nxtLine  = '0;
         end
      end else if (r_col != COL_LAST) begin
         w_nxtCol = r_col + 1'b1;
      end else begin
         w_nxtCol = '0;
         if (r_line != w_phaseLast) begin
            w_nxtLine = r_line + 1'b1;
         end else begin
            w_nxtLine = '0;
            case (r_state)
               ST_VSYNC:  w_nxtState = ST_VBACK;
               ST_VBACK:  w_nxtState = ST_ACTIVE;
               ST_ACTIVE: w_nxtState = ST_VFRONT;
               default: begin
                  // End of frame: chain straight into the next one when
                  // still enabled so Vsync rises on this same tick
                  w_nxtDone = 1'b1;
                  if (enable) begin
                     w_nxtState = ST_VSYNC;
                     w_nxtSel   = pattern_e'(pattern_sel);
                  end else begin
                     w_nxtState = ST_IDLE;
                     w_nxtBusy  = 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign w_nxtHref = (w_nxtState == ST_ACTIVE) && ({1'b0, w_nxtCol} < HREF_LIM);

   camera_pattern_gen #(
      .COL_W  (COL_W),
      .LINE_W (LINE_W)
   ) u_patternGen (
      .i_sel  (w_nxtSel),
      .i_col  (w_nxtCol),
      .i_line (w_nxtLine),
      .i_href (w_nxtHref),
      .o_byte (w_pattern)
   );

   // Frame FSM with registered outputs, all loaded from the next-state view
   // so the pins line up exactly with the state they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_col       <= '0;
         r_line      <= '0;
         r_sel       <= PAT_COUNT;
         r_vsync     <= 1'b0;
         r_href      <= 1'b0;
         r_imagen    <= 8'h00;
         r_frameDone <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         if (w_fallTick) begin
            r_state     <= w_nxtState;
            r_col       <= w_nxtCol;
            r_line      <= w_nxtLine;
            r_sel       <= w_nxtSel;
            r_busy      <= w_nxtBusy;
            r_frameDone <= w_nxtDone;
            r_vsync     <= (w_nxtState == ST_VSYNC);
            r_href      <= w_nxtHref;
            r_imagen    <= w_pattern;
         end
      end
   end

   assign Pclk       = r_pclk;
   assign Vsync      = r_vsync;
   assign Href       = r_href;
   assign Imagen     = r_imagen;
   assign frame_done = r_frameDone;
   assign busy       = r_busy;

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// tb_camera_sensor_emulator
// Directed bench for the camera sensor emulator. Instance dutA uses the
// default timing (Pclk = clk/2); instance dutB uses PCLK_DIV=2 (Pclk = clk/4).
// Frame position k counts Pclk rising edges from the first rise after Vsync
// goes high: Vsync k=0..39, back porch 40..79, active 80..159 (four lines of
// 16 data bytes + 4 blank), front porch 160..199.
module tb_camera_sensor_emulator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enA = 1'b0;
   logic       enB = 1'b0;
   logic [1:0] selA = 2'd0;
   logic [1:0] selB = 2'd0;
   logic       pclkA, vsyncA, hrefA, doneA, busyA;
   logic       pclkB, vsyncB, hrefB, doneB, busyB;
   logic [7:0] imgA, imgB;

   bit         useB = 1'b0;
   logic       sPclk, sVsync, sHref, sDone, sBusy;
   logic [7:0] sImg;

   int total = 0;
   int bad = 0;
   int doneSeen = 0;

   logic [7:0] imgArr [200];
   logic       hrefArr[200];

   camera_sensor_emulator dutA (
      .clk(clk), .rst(rst), .enable(enA), .pattern_sel(selA),
      .Pclk(pclkA), .Vsync(vsyncA), .Href(hrefA), .Imagen(imgA),
      .frame_done(doneA), .busy(busyA)
   );

   camera_sensor_emulator #(.PCLK_DIV(2)) dutB (
      .clk(clk), .rst(rst), .enable(enB), .pattern_sel(selB),
      .Pclk(pclkB), .Vsync(vsyncB), .Href(hrefB), .Imagen(imgB),
      .frame_done(doneB), .busy(busyB)
   );

   always #5 clk = ~clk;

   // Route whichever instance is under test onto one set of probe signals
   assign sPclk  = useB ? pclkB  : pclkA;
   assign sVsync = useB ? vsyncB : vsyncA;
   assign sHref  = useB ? hrefB  : hrefA;
   assign sImg   = useB ? imgB   : imgA;
   assign sDone  = useB ? doneB  : doneA;
   assign sBusy  = useB ? busyB  : busyA;

   // Expected byte for pattern sel at column c of active line y
   function automatic logic [7:0] pixModel(input int sel, input int c, input int y);
      case (sel)
         0:       return 8'(c);
         1:       return (c % 2 == 0) ? 8'hAA : 8'h55;
         2:       return {4'(y), 4'(c)};
         default: return 8'hFF;
      endcase
   endfunction

   // Drive the inputs of the instance under test
   task automatic applyStimulus(input bit en, input logic [1:0] sel);
      if (useB) begin
         enB = en;
         selB = sel;
      end else begin
         enA = en;
         selA = sel;
      end
   endtask

   // Advance to the next negedge sample at which Pclk has just risen
   task automatic nextRise(output bit ok);
      logic prev;
      prev = sPclk;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (sDone) doneSeen++;
         if (!prev && sPclk) begin
            ok = 1'b1;
            break;
         end
         prev = sPclk;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL pclk_rise: no Pclk rising edge within 40 clk, Pclk=%0b required toggling", sPclk);
      end
   endtask

   // Wait for Vsync to rise; leaves us at the sample right after frame start
   task automatic waitFrameStart(output bit ok);
      logic prev;
      prev = sVsync;
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (!prev && sVsync) begin
            ok = 1'b1;
            break;
         end
         prev = sVsync;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL frame_start: Vsync never rose, Vsync=%0b required 1", sVsync);
      end
   endtask

   // Capture one full frame and compare it against the model. At position
   // changeAt the inputs are changed to (newEn, newSel). expNext says whether
   // a new frame must start at the frame_done tick.
   task automatic captureFrame(input int expSel, input bit waitStart, input int changeAt,
                               input bit newEn, input logic [1:0] newSel, input bit expNext);
      bit ok;
      int errV, errH, errI, firstV, firstH, firstI;
      logic expV, expH;
      logic [7:0] expI, gotI;
      logic gotV, gotH;
      int c, y, n;
      errV = 0; errH = 0; errI = 0;
      firstV = -1; firstH = -1; firstI = -1;
      gotV = 1'b0; gotH = 1'b0; gotI = 8'h00; expI = 8'h00;
      ok = 1'b1;
      if (waitStart) waitFrameStart(ok);
      if (!ok) return;
      doneSeen = 0;
      for (int k = 0; k < 200; k++) begin
         if (k == changeAt) applyStimulus(newEn, newSel);
         nextRise(ok);
         if (!ok) return;
         expV = (k < 40);
         expH = 1'b0;
         c = 0;
         y = 0;
         if (k >= 80 && k < 160) begin
            c = (k - 80) % 20;
            y = (k - 80) / 20;
            expH = (c < 16);
         end
         imgArr[k]  = sImg;
         hrefArr[k] = sHref;
         if (sVsync !== expV) begin
            errV++;
            if (firstV < 0) begin firstV = k; gotV = sVsync; end
         end
         if (sHref !== expH) begin
            errH++;
            if (firstH < 0) begin firstH = k; gotH = sHref; end
         end
         if (sImg !== (expH ? pixModel(expSel, c, y) : 8'h00)) begin
            errI++;
            if (firstI < 0) begin
               firstI = k;
               gotI = sImg;
               expI = expH ? pixModel(expSel, c, y) : 8'h00;
            end
         end
      end
      total++;
      if (errV !== 0) begin
         bad++;
         $display("[TB] FAIL vsync_profile: %0d wrong samples, first k=%0d got %0b required %0b", errV, firstV, gotV, firstV < 40);
      end
      total++;
      if (errH !== 0) begin
         bad++;
         $display("[TB] FAIL href_profile: %0d wrong samples, first k=%0d got %0b required %0b", errH, firstH, gotH, ~gotH);
      end
      total++;
      if (errI !== 0) begin
         bad++;
         $display("[TB] FAIL imagen_profile sel=%0d: %0d wrong samples, first k=%0d got %02h required %02h", expSel, errI, firstI, gotI, expI);
      end
      total++;
      if (doneSeen !== 0) begin
         bad++;
         $display("[TB] FAIL done_early: frame_done seen %0d times inside frame, required 0", doneSeen);
      end
      // The end-of-frame tick is the next Pclk fall after rise 199
      n = 0;
      while (sPclk && n < 10) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sDone !== 1'b1) begin
         bad++;
         $display("[TB] FAIL frame_done: got %0b required 1 at frame end", sDone);
      end
      total++;
      if (sVsync !== expNext) begin
         bad++;
         $display("[TB] FAIL next_vsync: Vsync at frame end got %0b required %0b", sVsync, expNext);
      end
      total++;
      if (sBusy !== expNext) begin
         bad++;
         $display("[TB] FAIL busy_at_end: got %0b required %0b", sBusy, expNext);
      end
   endtask

   task automatic test_reset();
      logic e1, e2;
      int hits;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({pclkA, vsyncA, hrefA, doneA, busyA} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: {Pclk,Vsync,Href,done,busy} got %05b required 00000", {pclkA, vsyncA, hrefA, doneA, busyA});
      end
      total++;
      if (imgA !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_imagen: got %02h required 00", imgA);
      end
      total++;
      if (pclkB !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_pclkB: got %0b required 0", pclkB);
      end
      rst = 1'b1;
      // A: toggles each clk; B: two clk high, two clk low, first rise on clk 2
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         e1 = (i % 2 == 0);
         e2 = (((i + 1) / 2) % 2 == 1);
         total++;
         if (pclkA !== e1) begin
            bad++;
            $display("[TB] FAIL pclkA_toggle[%0d]: got %0b required %0b", i, pclkA, e1);
         end
         total++;
         if (pclkB !== e2) begin
            bad++;
            $display("[TB] FAIL pclkB_toggle[%0d]: got %0b required %0b", i, pclkB, e2);
         end
      end
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (vsyncA || hrefA || busyA || doneA) hits++;
      end
      total++;
      if (hits !== 0) begin
         bad++;
         $display("[TB] FAIL idle_quiet: %0d active samples with enable=0, required 0", hits);
      end
   endtask

   task automatic test_default_frame();
      useB = 1'b0;
      applyStimulus(1'b1, 2'd1);
      captureFrame(1, 1'b1, -1, 1'b1, 2'd1, 1'b1);
      total++;
      if (imgArr[80] !== 8'hAA || imgArr[81] !== 8'h55 || imgArr[95] !== 8'h55) begin
         bad++;
         $display("[TB] FAIL alt_bytes: got %02h %02h %02h required AA 55 55", imgArr[80], imgArr[81], imgArr[95]);
      end
      total++;
      if (hrefArr[96] !== 1'b0 || imgArr[96] !== 8'h00) begin
         bad++;
         $display("[TB] FAIL hblank: Href=%0b Imagen=%02h required 0 00", hrefArr[96], imgArr[96]);
      end
   endtask

   task automatic test_back_to_back();
      useB = 1'b0;
      // sel changes mid-frame: this frame keeps the alternating pattern
      captureFrame(1, 1'b0, 100, 1'b1, 2'd2, 1'b1);
      // Next frame shows the grid; enable dropped on active line 2
      captureFrame(2, 1'b0, 120, 1'b0, 2'd2, 1'b0);
      total++;
      if (imgArr[145] !== 8'h35) begin
         bad++;
         $display("[TB] FAIL grid_l3_b5: got %02h required 35", imgArr[145]);
      end
      total++;
      if (imgArr[95] !== 8'h0F) begin
         bad++;
         $display("[TB] FAIL grid_l0_b15: got %02h required 0F", imgArr[95]);
      end
   endtask

   task automatic test_enable_drop();
      int hits;
      hits = 0;
      @(negedge clk);
      for (int i = 0; i < 600; i++) begin
         if (vsyncA || hrefA || busyA || doneA) hits++;
         @(negedge clk);
      end
      total++;
      if (hits !== 0) begin
         bad++;
         $display("[TB] FAIL stays_idle: %0d active samples after enable drop, required 0", hits);
      end
   endtask

   task automatic test_div2_count();
      bit ok;
      int n;
      logic prev;
      useB = 1'b1;
      nextRise(ok);
      n = 0;
      prev = sPclk;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (!prev && sPclk) break;
         prev = sPclk;
      end
      total++;
      if (n !== 4) begin
         bad++;
         $display("[TB] FAIL pclkB_period: got %0d clk required 4", n);
      end
      applyStimulus(1'b1, 2'd0);
      captureFrame(0, 1'b1, 10, 1'b0, 2'd0, 1'b0);
      total++;
      if (imgArr[80] !== 8'h00 || imgArr[95] !== 8'h0F || imgArr[96] !== 8'h00) begin
         bad++;
         $display("[TB] FAIL count_line0: got %02h %02h %02h required 00 0F 00", imgArr[80], imgArr[95], imgArr[96]);
      end
      total++;
      if (imgArr[101] !== 8'h01 || imgArr[115] !== 8'h0F) begin
         bad++;
         $display("[TB] FAIL count_line1: got %02h %02h required 01 0F", imgArr[101], imgArr[115]);
      end
      useB = 1'b0;
   endtask

   task automatic test_async_reset();
      bit ok;
      useB = 1'b0;
      applyStimulus(1'b1, 2'd3);
      waitFrameStart(ok);
      if (!ok) return;
      for (int k = 0; k < 86; k++) begin
         nextRise(ok);
         if (!ok) return;
      end
      total++;
      if (hrefA !== 1'b1 || imgA !== 8'hFF) begin
         bad++;
         $display("[TB] FAIL white_active: Href=%0b Imagen=%02h required 1 FF", hrefA, imgA);
      end
      // Assert reset between clock edges and look before the next posedge
      #2 rst = 1'b0;
      #1;
      total++;
      if ({hrefA, vsyncA, busyA, pclkA} !== 4'b0 || imgA !== 8'h00) begin
         bad++;
         $display("[TB] FAIL async_reset: {Href,Vsync,busy,Pclk}=%04b Imagen=%02h required 0000 00", {hrefA, vsyncA, busyA, pclkA}, imgA);
      end
      applyStimulus(1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      $display("[TB] camera_sensor_emulator directed bench");
      test_reset();
      test_default_frame();
      test_back_to_back();
      test_enable_drop();
      test_div2_count();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
